// File: rtl/lstm_gate_mac.sv
// lstm_gate_mac -- one LSTM gate pre-activation (W * [x;h] + b) for FEATURES
// parallel lanes, streamed one input element per cycle from a synchronous
// buffer (read data returns one cycle after x_rd).
//
// Ports:
//   sys_clk, reset_n   clock (rising edge), async active-low reset
//   start              request one gate vector (ignored while busy)
//   x_addr, x_rd       input-buffer address / read enable (addr is 0 when idle)
//   x_data, w_col      element and its weight column, one cycle after x_rd
//   gate_out           saturated (acc >>> FRAC_BITS) per lane, held until next result
//   done               level, gate_out valid; busy high in RUN and DRAIN
//   bias_in            only when LSTM_GATE_BIAS_EN is defined: per-lane bias,
//                      preloaded into the accumulator as bias << FRAC_BITS

module lstm_gate_lane #(
  parameter int EB   = 8,
  parameter int AW   = 20,
  parameter int FRAC = 4
) (
  input  logic          sys_clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic          lat,
  input  logic [EB-1:0] bias,
  input  logic [EB-1:0] w,
  input  logic [EB-1:0] x,
  output logic [EB-1:0] res
);
  localparam logic signed [AW-1:0] SMAX = AW'(2**(EB-1)-1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [AW-1:0]   sh;
  logic signed [2*EB-1:0] prod;
  logic        [EB-1:0]   res_q, res_d;

  assign prod = $signed(w) * $signed(x);
  // arithmetic shift == floor division by 2^FRAC
  assign sh   = acc_q >>> FRAC;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = AW'($signed(bias)) <<< FRAC;
    else if (en) acc_d = acc_q + AW'(prod);
  end

  always_comb begin
    res_d = res_q;
    if (lat) begin
      if (sh > SMAX)      res_d = SMAX[EB-1:0];
      else if (sh < SMIN) res_d = SMIN[EB-1:0];
      else                res_d = sh[EB-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;
endmodule

module lstm_gate_mac #(
  parameter int ELEMENT_BITS = 8,
  parameter int FEATURES     = 4,
  parameter int VEC_LEN      = 8,
  parameter int ADDR_BITS    = 3,
  parameter int FRAC_BITS    = 4
) (
  input  logic                             sys_clk,
  input  logic                             reset_n,
  input  logic                             start,
  output logic [ADDR_BITS-1:0]             x_addr,
  output logic                             x_rd,
  input  logic [ELEMENT_BITS-1:0]          x_data,
  input  logic [FEATURES*ELEMENT_BITS-1:0] w_col,
`ifdef LSTM_GATE_BIAS_EN
  input  logic [FEATURES*ELEMENT_BITS-1:0] bias_in,
`endif
  output logic [FEATURES*ELEMENT_BITS-1:0] gate_out,
  output logic                             done,
  output logic                             busy
);
  localparam int AW = 2*ELEMENT_BITS + ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(VEC_LEN-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] x_addr_q, x_addr_d;
  logic                 x_rd_q, x_rd_d;
  logic                 rd_vld_q;   // x_rd delayed: x_data/w_col valid now
  logic                 done_q, done_d;
  logic                 clr, lat;
  logic [FEATURES*ELEMENT_BITS-1:0] bias_w;

`ifdef LSTM_GATE_BIAS_EN
  assign bias_w = bias_in;
`else
  assign bias_w = '0;
`endif

  always_comb begin
    state_d  = state_q;
    x_addr_d = '0;
    x_rd_d   = 1'b0;
    done_d   = done_q;
    clr      = 1'b0;
    lat      = 1'b0;
    case (state_q)
      IDLE: ;
      RUN: begin
        if (x_addr_q == LAST) begin
          state_d = DRAIN;
        end else begin
          x_rd_d   = 1'b1;
          x_addr_d = x_addr_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        // first DONE cycle: last product is in the accumulator, publish it
        if (!done_q) begin
          lat    = 1'b1;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d  = RUN;
      clr      = 1'b1;
      done_d   = 1'b0;
      x_rd_d   = 1'b1;
      x_addr_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x_addr_q <= '0;
      x_rd_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_addr_q <= x_addr_d;
      x_rd_q   <= x_rd_d;
      rd_vld_q <= x_rd_q;
      done_q   <= done_d;
    end
  end

  for (genvar f = 0; f < FEATURES; f++) begin : g_lane
    lstm_gate_lane #(.EB(ELEMENT_BITS), .AW(AW), .FRAC(FRAC_BITS)) u_lane (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .clr     (clr),
      .en      (rd_vld_q),
      .lat     (lat),
      .bias    (bias_w[f*ELEMENT_BITS +: ELEMENT_BITS]),
      .w       (w_col[f*ELEMENT_BITS +: ELEMENT_BITS]),
      .x       (x_data),
      .res     (gate_out[f*ELEMENT_BITS +: ELEMENT_BITS])
    );
  end

  assign x_addr = x_addr_q;
  assign x_rd   = x_rd_q;
  assign done   = done_q;
  assign busy   = (state_q == RUN) || (state_q == DRAIN);
endmodule

// File: tb/tb_lstm_gate_mac.sv
module tb_lstm_gate_mac;
  localparam int EB = 8, NF = 4, VL = 8, AB = 3, FB = 4;

  logic            sys_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic [AB-1:0]   x_addr;
  logic            x_rd;
  logic [EB-1:0]   x_data = '0;
  logic [NF*EB-1:0] w_col = '0;
  logic [NF*EB-1:0] bias_in = '0;
  logic [NF*EB-1:0] gate_out;
  logic            done, busy;

  lstm_gate_mac #(.ELEMENT_BITS(EB), .FEATURES(NF), .VEC_LEN(VL),
                  .ADDR_BITS(AB), .FRAC_BITS(FB)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start),
    .x_addr(x_addr), .x_rd(x_rd), .x_data(x_data), .w_col(w_col),
`ifdef LSTM_GATE_BIAS_EN
    .bias_in(bias_in),
`endif
    .gate_out(gate_out), .done(done), .busy(busy));

  always #5 sys_clk = ~sys_clk;

  // input buffer contents
  byte xm [VL];
  byte wm [VL][NF];
  byte bm [NF];
  int  addr_q[$];
  int  n_tests = 0, n_fail = 0;

  // synchronous-read buffer: data one cycle after x_rd
  always @(posedge sys_clk) begin
    if (x_rd) begin
      x_data <= xm[x_addr];
      for (int f = 0; f < NF; f++) w_col[f*EB +: EB] <= wm[x_addr][f];
      addr_q.push_back(int'(x_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: exact integer dot product, floor-divide, clamp
  function automatic logic [NF*EB-1:0] model();
    logic [NF*EB-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) begin
      int s, q;
      s = 0;
`ifdef LSTM_GATE_BIAS_EN
      s = int'(bm[f]) * (1 << FB);
`endif
      for (int i = 0; i < VL; i++) s += int'(wm[i][f]) * int'(xm[i]);
      q = (s - (((s % 16) + 16) % 16)) / 16;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      r[f*EB +: EB] = 8'(q);
    end
    return r;
  endfunction

  task automatic fill(input byte xv, input byte w0, input byte w1, input byte w2, input byte w3);
    for (int i = 0; i < VL; i++) begin
      xm[i] = xv; wm[i][0] = w0; wm[i][1] = w1; wm[i][2] = w2; wm[i][3] = w3;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < VL; i++) begin
      xm[i] = byte'($urandom);
      for (int f = 0; f < NF; f++) wm[i][f] = byte'($urandom);
    end
    for (int f = 0; f < NF; f++) bm[f] = byte'($urandom);
  endtask

  // one computation; optional stray start at RUN cycle 5
  task automatic run(input string tag, input bit mid_start);
    logic [NF*EB-1:0] exp;
    int k, bad0;
    exp = model();
    for (int f = 0; f < NF; f++) bias_in[f*EB +: EB] = bm[f];
    addr_q.delete();
    bad0 = 0;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 30) begin
      @(posedge sys_clk); #1;
      k++;
      if (k == 1) begin
        chk({tag, "_done_lo"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
      end
      if (!x_rd && x_addr != 0) bad0++;
      if (mid_start) start = (k == 4);
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(k), 64'(VL + 2));
    chk({tag, "_gate"}, 64'(gate_out), 64'(exp));
    chk({tag, "_nrd"}, 64'(addr_q.size()), 64'(VL));
    for (int i = 0; i < addr_q.size() && i < VL; i++)
      if (addr_q[i] != i) bad0++;
    chk({tag, "_addr"}, 64'(bad0), 64'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk({tag, "_hold"}, 64'({done, busy, gate_out}), 64'({1'b1, 1'b0, exp}));
  endtask

  initial begin
    for (int f = 0; f < NF; f++) bm[f] = 0;
    #12;
    chk("rst", 64'({gate_out, done, busy, x_rd, x_addr}), 64'd0);
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    fill(8'sh10, 8'sh08, 8'sh08, 8'sh08, 8'sh08);
    chk("ref031", 64'(model()), 64'h40404040 + 64'(0));
    run("r031", 1'b0);

    fill(8'sh10, -8'sh20, -8'sh10, 8'sh20, 8'sh00);
    run("r032", 1'b0);
    fill(8'sh01, -8'sh01, -8'sh01, -8'sh01, -8'sh01);
    run("r033", 1'b0);

    // stray start mid-RUN, then restart straight from DONE
    fill(8'sh10, 8'sh08, -8'sh08, 8'sh03, 8'sh7F);
    run("r034a", 1'b1);
    fill_rand();
    run("r034b", 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_rand();
      run($sformatf("rnd%0d", t), 1'b0);
    end

`ifdef LSTM_GATE_BIAS_EN
    fill(8'sh00, 8'sh00, 8'sh00, 8'sh00, 8'sh00);
    bm[0] = 8'sh10; bm[1] = -8'sh05; bm[2] = 8'sh7F; bm[3] = -8'sh80;
    run("r036", 1'b0);
`endif

    // reset mid-RUN
    fill_rand();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid", 64'({gate_out, done, busy, x_rd, x_addr}), 64'd0);
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(posedge sys_clk); #1;
        if (done || busy || x_rd) seen++;
      end
      chk("rst_nodone", 64'(seen), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lstm_gate_mac.md
LSTM_GATE_MAC -- requirements
Module: lstm_gate_mac

Interface
REQ-001 SHALL have parameter ELEMENT_BITS, default 8, width of one signed fixed-point element.
REQ-002 SHALL have parameter FEATURES, default 4, number of gate outputs (parallel lanes).
REQ-003 SHALL have parameter VEC_LEN, default 8, input-vector length (x plus h elements).
REQ-004 SHALL have parameter ADDR_BITS, default 3, input-buffer address width; 2^ADDR_BITS >= VEC_LEN.
REQ-005 SHALL have parameter FRAC_BITS, default 4, fractional bits of every element.
REQ-006 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, request to compute one gate vector.
REQ-009 SHALL have port x_addr, output, ADDR_BITS, input-buffer read address.
REQ-010 SHALL have port x_rd, output, 1, input-buffer chip-select/output-enable.
REQ-011 SHALL have port x_data, input, ELEMENT_BITS, buffer read data, valid one cycle after x_rd.
REQ-012 SHALL have port w_col, input, FEATURES*ELEMENT_BITS, weight column for the element on x_data, same cycle as x_data; lane f at bits [f*ELEMENT_BITS +: ELEMENT_BITS].
REQ-013 SHALL have port gate_out, output, FEATURES*ELEMENT_BITS, pre-activation vector, same lane packing.
REQ-014 SHALL have port done, output, 1, level: gate_out valid.
REQ-015 SHALL have port busy, output, 1, high in RUN and DRAIN.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE/DONE with start=1 SHALL go to RUN, clear accumulators, clear done, set x_addr=0, x_rd=1.
REQ-018 RUN SHALL increment x_addr each cycle; after issuing VEC_LEN-1 SHALL go to DRAIN with x_rd=0.
REQ-019 A registered data-valid (x_rd delayed one cycle) SHALL gate accumulation: acc[f] += signed(w_col[f]) * signed(x_data).
REQ-020 DRAIN SHALL last one cycle (final accumulate), then go to DONE, register gate_out and set done=1.
REQ-021 done SHALL rise exactly VEC_LEN+2 cycles after the edge sampling start, and SHALL hold until next start or reset.
REQ-022 start during RUN or DRAIN SHALL be ignored.
REQ-023 gate_out SHALL hold its value from DONE until the next DONE.
REQ-024 Accumulator width SHALL be 2*ELEMENT_BITS+ADDR_BITS+1, signed, no overflow possible.
REQ-025 Result SHALL be acc arithmetically shifted right FRAC_BITS (truncate toward minus infinity), then saturated to [-2^(ELEMENT_BITS-1), 2^(ELEMENT_BITS-1)-1].
REQ-026 x_addr SHALL be 0 whenever x_rd=0.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, accumulators 0, gate_out 0, done 0, busy 0, x_rd 0, x_addr 0.
REQ-028 Reset mid-RUN SHALL abort; no done pulse after release until a new start.

Configuration
REQ-029 Macro LSTM_GATE_BIAS_EN defined SHALL add input bias_in (FEATURES*ELEMENT_BITS); on start each acc[f] SHALL load sign-extended bias_in[f] << FRAC_BITS instead of 0.
REQ-030 Without LSTM_GATE_BIAS_EN, bias_in SHALL not exist and accumulators SHALL clear to 0.

Verification (ELEMENT_BITS=8, FRAC_BITS=4, VEC_LEN=8, FEATURES=4)
REQ-031 All x=0x10, all w=0x08 -> every lane 0x40; done at start+10 cycles; x_addr sequence 0..7.
REQ-032 x=0x10, w lane0=0xE0, lane1=0xF0, lane2=0x20, lane3=0x00 -> lanes 0x80 (sat), 0x80 (exact -128), 0x7F (sat), 0x00.
REQ-033 x=0x01, w=0xFF all elements -> each product -1, sum -8, >>>4 -> 0xFF (floor).
REQ-034 start pulsed again at cycle 5 of RUN -> ignored, result unchanged; start in DONE -> done low next cycle, new result after 10 cycles.
REQ-035 reset_n low at RUN cycle 4 -> all outputs 0 immediately; after release no done without start.
REQ-036 With LSTM_GATE_BIAS_EN, bias lane0=0x10, x=0, w=0 -> lane0 0x10, others bias values.
